axi_res_tbl_sched: RTL and testbench

- Scheduler directly upstream of the AXI reservation table in the RISC-V atomics adapter.
- Collects LR (load-reserved) completions from the read path and write/SC requests from the write path.
- Buffers LRs in a small FIFO and drives the table's set and check/clear ports with their req/gnt handshakes.
- Returns a per-write verdict (forward or drop, EXOKAY or OKAY) to the AW forwarding logic.
- Bounds LR starvation, because the table always grants check/clear ahead of set.

---
 rtl/axi_res_tbl_pkg.sv | 28 ++
 rtl/axi_res_lr_fifo.sv | 66 ++++++
 rtl/axi_res_tbl_sched.sv | 194 +++++++++++++++++++
 tb/tb_axi_res_tbl_sched.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_res_tbl_pkg.sv
// -----------------------------------------------------------------------------
// axi_res_tbl_pkg: shared types and helpers for the reservation-table scheduler.
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package axi_res_tbl_pkg;

  localparam int STAT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } sched_state_e;

  // lr_entry_t {addr, id} is declared in the module that uses it, because its
  // field widths come from that module's parameters.

  // Returns {forward, exokay}. A plain write always forwards. An SC forwards
  // only when the table still holds the reservation.
  function automatic logic [1:0] sc_verdict(input logic excl, input logic tbl_res);
    return {(!excl || tbl_res), (excl && tbl_res)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_res_lr_fifo.sv
// -----------------------------------------------------------------------------
// axi_res_lr_fifo: generic synchronous FIFO with full/empty flags.
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module axi_res_lr_fifo
  import axi_res_tbl_pkg::*;
#(
  parameter type entry_t = logic,
  parameter int  DEPTH   = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               w_push, w_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is taken only when the head leaves in the same cycle.
  assign w_push = push_i && (!full_o || pop_i);
  assign w_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/axi_res_tbl_sched.sv
// -----------------------------------------------------------------------------
// axi_res_tbl_sched: schedules LR sets and write/SC checks into the AXI
// reservation table. Optional: AXI_RES_TBL_SCHED_STATS_EN adds stat counters.
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module axi_res_tbl_sched
  import axi_res_tbl_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 0,
  parameter int AXI_ID_WIDTH   = 0,
  parameter int LR_FIFO_DEPTH  = 4,
  parameter int MAX_LR_WAIT    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0] lr_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   lr_id_i,
  input  logic                      lr_valid_i,
  output logic                      lr_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   wr_id_i,
  input  logic                      wr_excl_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  output logic                      res_ok_o,
  output logic                      res_exokay_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] check_clr_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   check_id_o,
  output logic                      check_clr_excl_o,
  output logic                      check_clr_req_o,
  input  logic                      check_clr_gnt_i,
  input  logic                      check_res_i,
  output logic [AXI_ADDR_WIDTH-1:0] set_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   set_id_o,
  output logic                      set_req_o,
  input  logic                      set_gnt_i
`ifdef AXI_RES_TBL_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_sc_fail_o,
  output logic [STAT_W-1:0]         stat_lr_stall_o
`endif
);

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_ID_WIDTH-1:0]   id;
  } lr_entry_t;

  localparam int                WAIT_W   = $clog2(MAX_LR_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_LR_WAIT);

  lr_entry_t w_lr_in, w_lr_head;
  logic      w_full, w_empty, w_set_fire, w_hold_wr;

  logic [WAIT_W-1:0]         wait_q, wait_d;
  sched_state_e              state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic                      excl_q, excl_d;
  logic                      ok_q, ok_d;
  logic                      exokay_q, exokay_d;

  // ---------------------------------------------------------------------------
  // LR buffer
  // ---------------------------------------------------------------------------
  assign w_lr_in    = '{addr: lr_addr_i, id: lr_id_i};
  assign w_set_fire = set_req_o && set_gnt_i;
  // A head pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign lr_ready_o = !w_full || w_set_fire;

  axi_res_lr_fifo #(
    .entry_t (lr_entry_t),
    .DEPTH   (LR_FIFO_DEPTH)
  ) u_lr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (lr_valid_i && lr_ready_o),
    .data_i  (w_lr_in),
    .pop_i   (w_set_fire),
    .data_o  (w_lr_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign set_addr_o = w_lr_head.addr;
  assign set_id_o   = w_lr_head.id;
  assign set_req_o  = !w_empty && !(check_clr_req_o && !w_hold_wr);

  // ---------------------------------------------------------------------------
  // Starvation counter: once saturated, write checks yield to the pending set.
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_d = wait_q;
    if (w_empty || w_set_fire) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign w_hold_wr = (wait_q == WAIT_MAX);

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    id_d            = id_q;
    excl_d          = excl_q;
    ok_d            = ok_q;
    exokay_d        = exokay_q;
    wr_ready_o      = 1'b0;
    check_clr_req_o = 1'b0;
    res_valid_o     = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready_o = !w_hold_wr;
        if (wr_valid_i && !w_hold_wr) begin
          addr_d  = wr_addr_i;
          id_d    = wr_id_i;
          excl_d  = wr_excl_i;
          state_d = CHECK;
        end
      end
      CHECK: begin
        check_clr_req_o = !w_hold_wr;
        if (!w_hold_wr && check_clr_gnt_i) begin
          {ok_d, exokay_d} = sc_verdict(excl_q, check_res_i);
          state_d          = RESP;
        end
      end
      RESP: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign check_clr_addr_o = addr_q;
  assign check_id_o       = id_q;
  assign check_clr_excl_o = excl_q;
  assign res_ok_o         = ok_q;
  assign res_exokay_o     = exokay_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      excl_q   <= 1'b0;
      ok_q     <= 1'b0;
      exokay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      excl_q   <= excl_d;
      ok_q     <= ok_d;
      exokay_q <= exokay_d;
    end
  end

`ifdef AXI_RES_TBL_SCHED_STATS_EN
  logic [STAT_W-1:0] sc_fail_q, lr_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sc_fail_q  <= '0;
      lr_stall_q <= '0;
    end else begin
      if (state_q == CHECK && check_clr_req_o && check_clr_gnt_i && excl_q && !check_res_i) begin
        sc_fail_q <= sc_fail_q + STAT_W'(1);
      end
      if (w_hold_wr) begin
        lr_stall_q <= lr_stall_q + STAT_W'(1);
      end
    end
  end

  assign stat_sc_fail_o  = sc_fail_q;
  assign stat_lr_stall_o = lr_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_res_tbl_sched.sv
// -----------------------------------------------------------------------------
// tb_axi_res_tbl_sched: directed scoreboard bench for axi_res_tbl_sched.
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_axi_res_tbl_sched;

  localparam int AW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] lr_addr, wr_addr, check_clr_addr, set_addr;
  logic [IW-1:0] lr_id, wr_id, check_id, set_id;
  logic          lr_valid, lr_ready, wr_excl, wr_valid, wr_ready;
  logic          res_ok, res_exokay, res_valid, res_ready;
  logic          check_clr_excl, check_clr_req, check_clr_gnt, check_res;
  logic          set_req, set_gnt;
  logic          tbl_chk_en, tbl_set_en, tbl_res;
`ifdef AXI_RES_TBL_SCHED_STATS_EN
  logic [31:0]   stat_sc_fail, stat_lr_stall;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
  } lr_t;

  lr_t        lr_q  [$];
  logic [1:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // Table model: grants whichever request it is currently willing to serve.
  assign check_clr_gnt = check_clr_req && tbl_chk_en;
  assign set_gnt       = set_req && tbl_set_en;
  assign check_res     = tbl_res;

  axi_res_tbl_sched #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_ID_WIDTH   (IW),
    .LR_FIFO_DEPTH  (4),
    .MAX_LR_WAIT    (8)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .lr_addr_i        (lr_addr),
    .lr_id_i          (lr_id),
    .lr_valid_i       (lr_valid),
    .lr_ready_o       (lr_ready),
    .wr_addr_i        (wr_addr),
    .wr_id_i          (wr_id),
    .wr_excl_i        (wr_excl),
    .wr_valid_i       (wr_valid),
    .wr_ready_o       (wr_ready),
    .res_ok_o         (res_ok),
    .res_exokay_o     (res_exokay),
    .res_valid_o      (res_valid),
    .res_ready_i      (res_ready),
    .check_clr_addr_o (check_clr_addr),
    .check_id_o       (check_id),
    .check_clr_excl_o (check_clr_excl),
    .check_clr_req_o  (check_clr_req),
    .check_clr_gnt_i  (check_clr_gnt),
    .check_res_i      (check_res),
    .set_addr_o       (set_addr),
    .set_id_o         (set_id),
    .set_req_o        (set_req),
    .set_gnt_i        (set_gnt)
`ifdef AXI_RES_TBL_SCHED_STATS_EN
    ,
    .stat_sc_fail_o   (stat_sc_fail),
    .stat_lr_stall_o  (stat_lr_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_lr(input logic [AW-1:0] a, input logic [IW-1:0] id);
    lr_addr  = a;
    lr_id    = id;
    lr_valid = 1'b1;
    settle();
    chk("lr_ready", {63'd0, lr_ready}, 64'd1);
    lr_q.push_back('{addr: a, id: id});
    tick();
    lr_valid = 1'b0;
  endtask

  // Pops expected LRs as the table grants sets; assumes the table accepts sets.
  task automatic drain_lr();
    int n = 0;
    settle();
    while (set_req && n < 16) begin
      if (lr_q.size() == 0) begin
        chk("lr_extra_pop", 64'd1, 64'd0);
      end else begin
        lr_t e = lr_q.pop_front();
        chk("set_addr", {32'd0, set_addr}, {32'd0, e.addr});
        chk("set_id", {60'd0, set_id}, {60'd0, e.id});
      end
      tick();
      n++;
    end
    chk("lr_drained", 64'(lr_q.size()), 64'd0);
    chk("set_req_idle", {63'd0, set_req}, 64'd0);
  endtask

  task automatic check_verdict(input string tag);
    logic [1:0] e;
    chk({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {62'd0, res_ok, res_exokay}, {62'd0, e});
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [IW-1:0] id,
                          input logic ex, input logic r, input int hold);
    int n;
    logic [1:0] e;
    wr_addr  = a;
    wr_id    = id;
    wr_excl  = ex;
    wr_valid = 1'b1;
    tbl_res  = r;
    e = {(!ex || r), (ex && r)};
    exp_q.push_back(e);
    settle();
    chk("wr_ready", {63'd0, wr_ready}, 64'd1);
    tick();
    wr_valid = 1'b0;
    chk("chk_req", {63'd0, check_clr_req}, 64'd1);
    chk("chk_excl", {63'd0, check_clr_excl}, {63'd0, ex});
    chk("chk_addr", {32'd0, check_clr_addr}, {32'd0, a});
    chk("chk_id", {60'd0, check_id}, {60'd0, id});
    n = 1;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd2);
    check_verdict("verdict");
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("verdict_held", {61'd0, res_valid, res_ok, res_exokay}, {61'd0, 1'b1, e});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("verdict_done", {63'd0, res_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    lr_t e;
    rst        = 1'b1;
    lr_addr    = '0;
    lr_id      = '0;
    lr_valid   = 1'b0;
    wr_addr    = '0;
    wr_id      = '0;
    wr_excl    = 1'b0;
    wr_valid   = 1'b0;
    res_ready  = 1'b0;
    tbl_chk_en = 1'b1;
    tbl_set_en = 1'b1;
    tbl_res    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    settle();

    // Reset state
    chk("rst_lr_ready", {63'd0, lr_ready}, 64'd1);
    chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_chk_req", {63'd0, check_clr_req}, 64'd0);
    chk("rst_set_req", {63'd0, set_req}, 64'd0);
    chk("rst_res_ok", {63'd0, res_ok}, 64'd0);
    chk("rst_res_exokay", {63'd0, res_exokay}, 64'd0);

    // 1: LR then successful SC
    push_lr(32'h100, 4'd3);
    drain_lr();
    do_write(32'h100, 4'd3, 1'b1, 1'b1, 0);

    // 2: SC without reservation, verdict held for 5 cycles
    do_write(32'h200, 4'd2, 1'b1, 1'b0, 5);

    // 3: plain write always forwards
    do_write(32'h100, 4'd5, 1'b0, 1'b0, 0);

    // 4: fill the LR FIFO, stall the 5th, accept it on the first pop
    tbl_set_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_lr(32'h300 + 32'(i), 4'(i));
    end
    lr_addr  = 32'h304;
    lr_id    = 4'd4;
    lr_valid = 1'b1;
    settle();
    chk("lr_full", {63'd0, lr_ready}, 64'd0);
    tick();
    tick();
    chk("lr_stalled", {63'd0, lr_ready}, 64'd0);
    tbl_set_en = 1'b1;
    settle();
    chk("lr_push_pop", {63'd0, lr_ready}, 64'd1);
    e = lr_q.pop_front();
    chk("pp_set_id", {60'd0, set_id}, {60'd0, e.id});
    lr_q.push_back('{addr: 32'h304, id: 4'd4});
    tick();
    lr_valid = 1'b0;
    drain_lr();

    // 5: check starves the set until hold_wr yields to it
    tbl_chk_en = 1'b0;
    wr_addr    = 32'h400;
    wr_id      = 4'd1;
    wr_excl    = 1'b0;
    wr_valid   = 1'b1;
    lr_addr    = 32'h500;
    lr_id      = 4'd7;
    lr_valid   = 1'b1;
    settle();
    chk("same_cycle_lr", {63'd0, lr_ready}, 64'd1);
    chk("same_cycle_wr", {63'd0, wr_ready}, 64'd1);
    lr_q.push_back('{addr: 32'h500, id: 4'd7});
    tick();
    lr_valid = 1'b0;
    chk("starve_chk_req", {63'd0, check_clr_req}, 64'd1);
    chk("starve_set_blocked", {63'd0, set_req}, 64'd0);
    n = 0;
    while (check_clr_req && n < 20) begin
      tick();
      n++;
    end
    chk("starve_cycles", 64'(n), 64'd8);
    chk("starve_set_req", {63'd0, set_req}, 64'd1);
    e = lr_q.pop_front();
    chk("starve_set_addr", {32'd0, set_addr}, {32'd0, e.addr});
    tick();
    chk("starve_resume", {63'd0, check_clr_req}, 64'd1);
    chk("starve_fifo_empty", {63'd0, set_req}, 64'd0);
`ifdef AXI_RES_TBL_SCHED_STATS_EN
    chk("stat_lr_stall", {32'd0, stat_lr_stall}, 64'd1);
    chk("stat_sc_fail", {32'd0, stat_sc_fail}, 64'd1);
`endif
    wr_valid   = 1'b0;
    tbl_res    = 1'b0;
    exp_q.push_back(2'b10);
    tbl_chk_en = 1'b1;
    settle();
    tick();
    check_verdict("starve_verdict");
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("starve_wr_ready", {63'd0, wr_ready}, 64'd1);

    // 6: reset while in CHECK with two LRs buffered
    tbl_set_en = 1'b0;
    tbl_chk_en = 1'b0;
    push_lr(32'h600, 4'd1);
    push_lr(32'h610, 4'd2);
    wr_addr  = 32'h700;
    wr_id    = 4'd2;
    wr_excl  = 1'b1;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("pre_rst_chk_req", {63'd0, check_clr_req}, 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_set_req", {63'd0, set_req}, 64'd0);
    chk("mid_rst_chk_req", {63'd0, check_clr_req}, 64'd0);
    chk("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("mid_rst_lr_ready", {63'd0, lr_ready}, 64'd1);
    chk("mid_rst_wr_ready", {63'd0, wr_ready}, 64'd1);
`ifdef AXI_RES_TBL_SCHED_STATS_EN
    chk("mid_rst_stat_sc", {32'd0, stat_sc_fail}, 64'd0);
    chk("mid_rst_stat_lr", {32'd0, stat_lr_stall}, 64'd0);
`endif
    rst = 1'b0;
    lr_q.delete();
    tbl_chk_en = 1'b1;
    tbl_set_en = 1'b1;
    settle();
    chk("post_rst_set_req", {63'd0, set_req}, 64'd0);
    do_write(32'h600, 4'd1, 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
